portal_beat_scheduler: RTL and testbench

Arbitrates the AXI read-address (AR) and write-address (AW) request streams from the MAXIGP0 slave into one shared portal register-access port. It holds one pending request per channel and grants them round-robin. Each granted burst expands into per-beat accesses, with the address advancing by 4 per beat. Write beats pair with incoming W data. The block sits between the AXI ingress FIFOs and the portal control/user register datapath, and replaces the separate read and write beat paths with a single sequenced one.

---
 rtl/portal_axi_pkg.sv | 28 ++
 rtl/portal_burst_seq.sv | 50 +++++
 rtl/portal_beat_scheduler.sv | 150 +++++++++++++++
 tb/tb_portal_beat_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/portal_axi_pkg.sv
// Shared types for the portal AXI beat scheduler: FSM states, the round-robin
// priority and the per-channel holding-register layout.
package portal_axi_pkg;

  localparam int unsigned REQ_ADDR_W = 5;
  localparam int unsigned REQ_ID_W   = 6;
  localparam int unsigned REQ_LEN_W  = 4;
  localparam int unsigned BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } sched_state_t;

  typedef enum logic {
    PRIO_READ,
    PRIO_WRITE
  } prio_t;

  // count holds beats still to issue (len+1 at load), so it needs LEN_W+1 bits
  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_ID_W-1:0]   id;
    logic [REQ_LEN_W:0]    count;
  } req_t;

endpackage

// File: rtl/portal_burst_seq.sv
// One channel's pending-request holding register with per-beat address/count
// advance; the scheduler instantiates one for AR and one for AW.
module portal_burst_seq
  import portal_axi_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  load,
  input  logic [REQ_ADDR_W-1:0] ld_addr,
  input  logic [REQ_ID_W-1:0]   ld_id,
  input  logic [REQ_LEN_W-1:0]  ld_len,
  input  logic                  fire,
  input  logic                  clear,
  output logic                  full,
  output logic [REQ_ADDR_W-1:0] req_addr,
  output logic [REQ_ID_W-1:0]   req_id,
  output logic                  last
);

  localparam logic [REQ_LEN_W:0] COUNT_ONE = (REQ_LEN_W+1)'(1);

  req_t req;

  // load only happens while empty and fire only while granted (full), so the
  // two never coincide; clear lands on the final fire
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full <= 1'b0;
      req  <= '0;
    end else begin
      if (load) begin
        full      <= 1'b1;
        req.addr  <= ld_addr;
        req.id    <= ld_id;
        req.count <= {1'b0, ld_len} + COUNT_ONE;
      end else if (fire) begin
        req.addr  <= req.addr + REQ_ADDR_W'(BEAT_BYTES);
        req.count <= req.count - COUNT_ONE;
      end
      if (clear) begin
        full <= 1'b0;
      end
    end
  end

  assign req_addr = req.addr;
  assign req_id   = req.id;
  assign last     = (req.count == COUNT_ONE);

endmodule

// File: rtl/portal_beat_scheduler.sv
// Round-robin AR/AW arbiter expanding bursts into single register-port beats.
// Optional w_last consistency check: PORTAL_BEAT_SCHED_WLAST_CHECK_EN.
module portal_beat_scheduler
  import portal_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = REQ_ADDR_W,
  parameter int unsigned ID_W   = REQ_ID_W,
  parameter int unsigned LEN_W  = REQ_LEN_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ar_enq__ENA,
  output logic              ar_enq__RDY,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [LEN_W-1:0]  ar_len,
  input  logic              aw_enq__ENA,
  output logic              aw_enq__RDY,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic              w_enq__ENA,
  output logic              w_enq__RDY,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_last,
  output logic              acc__ENA,
  input  logic              acc__RDY,
  output logic              acc_write,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [ID_W-1:0]   acc_id,
  output logic              acc_last,
  output logic [DATA_W-1:0] acc_data,
  output logic              err_wlast
);

  sched_state_t state, state_nx;
  prio_t        prio, prio_nx;

  logic              ar_full, aw_full, ar_last, aw_last;
  logic              ar_fire, aw_fire, ar_clear, aw_clear;
  logic [ADDR_W-1:0] ar_cur_addr, aw_cur_addr;
  logic [ID_W-1:0]   ar_cur_id, aw_cur_id;

  assign ar_enq__RDY = !ar_full;
  assign aw_enq__RDY = !aw_full;

  portal_burst_seq u_ar_seq (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (ar_enq__ENA & !ar_full),
    .ld_addr  (ar_addr),
    .ld_id    (ar_id),
    .ld_len   (ar_len),
    .fire     (ar_fire),
    .clear    (ar_clear),
    .full     (ar_full),
    .req_addr (ar_cur_addr),
    .req_id   (ar_cur_id),
    .last     (ar_last)
  );

  portal_burst_seq u_aw_seq (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (aw_enq__ENA & !aw_full),
    .ld_addr  (aw_addr),
    .ld_id    (aw_id),
    .ld_len   (aw_len),
    .fire     (aw_fire),
    .clear    (aw_clear),
    .full     (aw_full),
    .req_addr (aw_cur_addr),
    .req_id   (aw_cur_id),
    .last     (aw_last)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      prio  <= PRIO_READ;
    end else begin
      state <= state_nx;
      prio  <= prio_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    prio_nx    = prio;
    acc__ENA   = 1'b0;
    acc_write  = 1'b0;
    w_enq__RDY = 1'b0;
    ar_fire    = 1'b0;
    aw_fire    = 1'b0;
    ar_clear   = 1'b0;
    aw_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (ar_full && (!aw_full || prio == PRIO_READ)) begin
          state_nx = READ;
        end else if (aw_full) begin
          state_nx = WRITE;
        end
      end
      READ: begin
        acc__ENA = 1'b1;
        ar_fire  = acc__RDY;
        if (ar_fire && ar_last) begin
          ar_clear = 1'b1;
          state_nx = IDLE;
          prio_nx  = PRIO_WRITE;
        end
      end
      WRITE: begin
        // a write beat exists only while W data is presented alongside it
        acc__ENA   = w_enq__ENA;
        acc_write  = 1'b1;
        w_enq__RDY = acc__RDY;
        aw_fire    = w_enq__ENA & acc__RDY;
        if (aw_fire && aw_last) begin
          aw_clear = 1'b1;
          state_nx = IDLE;
          prio_nx  = PRIO_READ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign acc_addr = (state == WRITE) ? aw_cur_addr : ar_cur_addr;
  assign acc_id   = (state == WRITE) ? aw_cur_id   : ar_cur_id;
  assign acc_last = ((state == READ) && ar_last) || ((state == WRITE) && aw_last);
  assign acc_data = (state == WRITE) ? w_data : '0;

`ifdef PORTAL_BEAT_SCHED_WLAST_CHECK_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      err_wlast <= 1'b0;
    end else if (aw_fire && (w_last != aw_last)) begin
      err_wlast <= 1'b1;
    end
  end
`else
  logic unused_w_last;
  assign unused_w_last = w_last;
  assign err_wlast     = 1'b0;
`endif

endmodule

// File: tb/tb_portal_beat_scheduler.sv
// Directed self-checking bench for portal_beat_scheduler.
module tb_portal_beat_scheduler;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ar_enq__ENA, ar_enq__RDY;
  logic [4:0]  ar_addr;
  logic [5:0]  ar_id;
  logic [3:0]  ar_len;
  logic        aw_enq__ENA, aw_enq__RDY;
  logic [4:0]  aw_addr;
  logic [5:0]  aw_id;
  logic [3:0]  aw_len;
  logic        w_enq__ENA, w_enq__RDY;
  logic [31:0] w_data;
  logic        w_last;
  logic        acc__ENA, acc__RDY, acc_write, acc_last, err_wlast;
  logic [4:0]  acc_addr;
  logic [5:0]  acc_id;
  logic [31:0] acc_data;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PORTAL_BEAT_SCHED_WLAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 CLK = ~CLK;

  portal_beat_scheduler #(.ADDR_W(5), .ID_W(6), .LEN_W(4), .DATA_W(32)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ar_enq__ENA (ar_enq__ENA),
    .ar_enq__RDY (ar_enq__RDY),
    .ar_addr     (ar_addr),
    .ar_id       (ar_id),
    .ar_len      (ar_len),
    .aw_enq__ENA (aw_enq__ENA),
    .aw_enq__RDY (aw_enq__RDY),
    .aw_addr     (aw_addr),
    .aw_id       (aw_id),
    .aw_len      (aw_len),
    .w_enq__ENA  (w_enq__ENA),
    .w_enq__RDY  (w_enq__RDY),
    .w_data      (w_data),
    .w_last      (w_last),
    .acc__ENA    (acc__ENA),
    .acc__RDY    (acc__RDY),
    .acc_write   (acc_write),
    .acc_addr    (acc_addr),
    .acc_id      (acc_id),
    .acc_last    (acc_last),
    .acc_data    (acc_data),
    .err_wlast   (err_wlast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    ar_enq__ENA = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0;
    aw_enq__ENA = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0;
    w_enq__ENA = 1'b0; w_data = '0; w_last = 1'b0;
    acc__RDY = 1'b1;

    // reset state
    step(); step(); #2;
    chk("rst_ar_rdy", ar_enq__RDY, 1);
    chk("rst_aw_rdy", aw_enq__RDY, 1);
    chk("rst_acc_ena", acc__ENA, 0);
    chk("rst_w_rdy", w_enq__RDY, 0);
    chk("rst_acc_last", acc_last, 0);
    chk("rst_err_wlast", err_wlast, 0);

    // single read: addr 8, id 3, len 2
    step(); nRST = 1'b1;
    ar_enq__ENA = 1'b1; ar_addr = 5'd8; ar_id = 6'd3; ar_len = 4'd2; #2;
    chk("rd_ar_rdy_n", ar_enq__RDY, 1);
    step(); ar_enq__ENA = 1'b0; #2;
    chk("rd_idle_ena", acc__ENA, 0);
    chk("rd_ar_rdy_n1", ar_enq__RDY, 0);
    step(); #2;
    chk("rd_b0_ena", acc__ENA, 1);
    chk("rd_b0_write", acc_write, 0);
    chk("rd_b0_addr", acc_addr, 8);
    chk("rd_b0_id", acc_id, 3);
    chk("rd_b0_last", acc_last, 0);
    chk("rd_b0_data", acc_data, 0);
    step(); #2;
    chk("rd_b1_addr", acc_addr, 12);
    chk("rd_b1_last", acc_last, 0);
    step(); #2;
    chk("rd_b2_addr", acc_addr, 16);
    chk("rd_b2_id", acc_id, 3);
    chk("rd_b2_last", acc_last, 1);
    step(); #2;
    chk("rd_done_ena", acc__ENA, 0);
    chk("rd_done_ar_rdy", ar_enq__RDY, 1);

    // wrap: addr 28, len 1
    ar_enq__ENA = 1'b1; ar_addr = 5'd28; ar_id = 6'd1; ar_len = 4'd1;
    step(); ar_enq__ENA = 1'b0; #2;
    chk("wr_idle_ena", acc__ENA, 0);
    step(); #2;
    chk("wrap_b0_addr", acc_addr, 28);
    chk("wrap_b0_last", acc_last, 0);
    step(); #2;
    chk("wrap_b1_addr", acc_addr, 0);
    chk("wrap_b1_last", acc_last, 1);
    step(); #2;
    chk("wrap_done_ena", acc__ENA, 0);

    // collision with prio on WRITE (last completion was a read)
    ar_enq__ENA = 1'b1; ar_addr = 5'd12; ar_id = 6'd7; ar_len = 4'd0;
    aw_enq__ENA = 1'b1; aw_addr = 5'd16; aw_id = 6'd9; aw_len = 4'd0;
    step(); ar_enq__ENA = 1'b0; aw_enq__ENA = 1'b0; #2;
    chk("rr_idle_ena", acc__ENA, 0);
    chk("rr_ar_rdy", ar_enq__RDY, 0);
    chk("rr_aw_rdy", aw_enq__RDY, 0);
    step(); w_enq__ENA = 1'b1; w_data = 32'hCAFE0001; w_last = 1'b1; #2;
    chk("rr_write_first", acc_write, 1);
    chk("rr_w_ena", acc__ENA, 1);
    chk("rr_w_addr", acc_addr, 16);
    chk("rr_w_id", acc_id, 9);
    chk("rr_w_data", acc_data, 32'hCAFE0001);
    chk("rr_w_rdy", w_enq__RDY, 1);
    step(); w_enq__ENA = 1'b0; w_last = 1'b0; #2;
    chk("rr_gap_ena", acc__ENA, 0);
    chk("rr_gap_aw_rdy", aw_enq__RDY, 1);
    chk("rr_gap_ar_rdy", ar_enq__RDY, 0);
    step(); #2;
    chk("rr_r_ena", acc__ENA, 1);
    chk("rr_r_write", acc_write, 0);
    chk("rr_r_addr", acc_addr, 12);
    chk("rr_r_id", acc_id, 7);
    step(); #2;
    chk("rr_done_ena", acc__ENA, 0);

    // collision right after reset: read wins, then write, prio ends READ
    nRST = 1'b0;
    step(); nRST = 1'b1;
    ar_enq__ENA = 1'b1; ar_addr = 5'd4; ar_id = 6'd1; ar_len = 4'd0;
    aw_enq__ENA = 1'b1; aw_addr = 5'd20; aw_id = 6'd2; aw_len = 4'd0;
    step(); ar_enq__ENA = 1'b0; aw_enq__ENA = 1'b0; #2;
    chk("col_idle_ena", acc__ENA, 0);
    step(); #2;
    chk("col_read_first", acc_write, 0);
    chk("col_r_addr", acc_addr, 4);
    chk("col_r_id", acc_id, 1);
    chk("col_r_last", acc_last, 1);
    step(); #2;
    chk("col_gap_ena", acc__ENA, 0);
    chk("col_gap_w_rdy", w_enq__RDY, 0);
    chk("col_gap_ar_rdy", ar_enq__RDY, 1);
    chk("col_gap_aw_rdy", aw_enq__RDY, 0);
    step(); w_enq__ENA = 1'b1; w_data = 32'hCAFE0002; w_last = 1'b1; #2;
    chk("col_w_write", acc_write, 1);
    chk("col_w_addr", acc_addr, 20);
    chk("col_w_id", acc_id, 2);
    chk("col_w_last", acc_last, 1);
    chk("col_w_data", acc_data, 32'hCAFE0002);
    step(); w_enq__ENA = 1'b0; w_last = 1'b0; #2;
    chk("col_done_ena", acc__ENA, 0);

    // second collision shows prio returned to READ
    ar_enq__ENA = 1'b1; ar_addr = 5'd24; ar_id = 6'd5; ar_len = 4'd0;
    aw_enq__ENA = 1'b1; aw_addr = 5'd8; aw_id = 6'd6; aw_len = 4'd0;
    step(); ar_enq__ENA = 1'b0; aw_enq__ENA = 1'b0;
    step(); #2;
    chk("prio_read_again", acc_write, 0);
    chk("prio_r_id", acc_id, 5);
    step();
    step(); w_enq__ENA = 1'b1; w_data = 32'h3; w_last = 1'b1; #2;
    chk("prio_w_write", acc_write, 1);
    chk("prio_w_id", acc_id, 6);
    step(); w_enq__ENA = 1'b0; w_last = 1'b0; #2;
    chk("prio_done_ena", acc__ENA, 0);

    // backpressure: 4 write beats with W alternating, 7 cycles
    aw_enq__ENA = 1'b1; aw_addr = 5'd0; aw_id = 6'd4; aw_len = 4'd3;
    step(); aw_enq__ENA = 1'b0; #2;
    chk("bp_idle_w_rdy", w_enq__RDY, 0);
    step(); w_enq__ENA = 1'b1; w_data = 32'h11; #2;
    chk("bp_b0_ena", acc__ENA, 1);
    chk("bp_b0_addr", acc_addr, 0);
    chk("bp_b0_data", acc_data, 32'h11);
    chk("bp_b0_w_rdy", w_enq__RDY, 1);
    chk("bp_b0_last", acc_last, 0);
    step(); w_enq__ENA = 1'b0; #2;
    chk("bp_gap0_ena", acc__ENA, 0);
    chk("bp_gap0_w_rdy", w_enq__RDY, 1);
    chk("bp_gap0_addr", acc_addr, 4);
    step(); w_enq__ENA = 1'b1; w_data = 32'h22; #2;
    chk("bp_b1_addr", acc_addr, 4);
    chk("bp_b1_data", acc_data, 32'h22);
    step(); w_enq__ENA = 1'b0; #2;
    step(); w_enq__ENA = 1'b1; w_data = 32'h33; #2;
    chk("bp_b2_addr", acc_addr, 8);
    chk("bp_b2_last", acc_last, 0);
    step(); w_enq__ENA = 1'b0; #2;
    step(); w_enq__ENA = 1'b1; w_data = 32'h44; w_last = 1'b1; #2;
    chk("bp_b3_addr", acc_addr, 12);
    chk("bp_b3_data", acc_data, 32'h44);
    chk("bp_b3_last", acc_last, 1);
    step(); w_enq__ENA = 1'b0; w_last = 1'b0; #2;
    chk("bp_done_w_rdy", w_enq__RDY, 0);
    chk("bp_done_ena", acc__ENA, 0);
    chk("bp_done_aw_rdy", aw_enq__RDY, 1);

    // max length with one held-off first beat
    ar_enq__ENA = 1'b1; ar_addr = 5'd0; ar_id = 6'd10; ar_len = 4'd15;
    step(); ar_enq__ENA = 1'b0; acc__RDY = 1'b0; #2;
    step(); #2;
    chk("max_hold_ena", acc__ENA, 1);
    chk("max_hold_addr", acc_addr, 0);
    for (int i = 0; i < 16; i++) begin
      step(); acc__RDY = 1'b1; #2;
      chk("max_addr", acc_addr, 32'((i * 4) % 32));
      chk("max_last", acc_last, (i == 15) ? 32'd1 : 32'd0);
      chk("max_ar_rdy", ar_enq__RDY, 0);
    end
    step(); #2;
    chk("max_done_ena", acc__ENA, 0);
    chk("max_done_ar_rdy", ar_enq__RDY, 1);

    // reset during beat 2 of 4
    ar_enq__ENA = 1'b1; ar_addr = 5'd0; ar_id = 6'd2; ar_len = 4'd3;
    step(); ar_enq__ENA = 1'b0; #2;
    step(); #2;
    chk("mrst_b0_addr", acc_addr, 0);
    step(); nRST = 1'b0; #2;
    chk("mrst_b1_ena", acc__ENA, 1);
    chk("mrst_b1_addr", acc_addr, 4);
    step(); #2;
    chk("mrst_ena", acc__ENA, 0);
    chk("mrst_ar_rdy", ar_enq__RDY, 1);
    chk("mrst_aw_rdy", aw_enq__RDY, 1);
    nRST = 1'b1;
    step(); #2;
    chk("mrst_no_more", acc__ENA, 0);

    // early w_last on beat 1 of 2
    aw_enq__ENA = 1'b1; aw_addr = 5'd0; aw_id = 6'd3; aw_len = 4'd1;
    step(); aw_enq__ENA = 1'b0; #2;
    step(); w_enq__ENA = 1'b1; w_data = 32'h55; w_last = 1'b1; #2;
    chk("wl_b0_last", acc_last, 0);
    chk("wl_b0_err", err_wlast, 0);
    step(); w_data = 32'h66; w_last = 1'b1; #2;
    chk("wl_b1_err", err_wlast, EXP_ERR);
    chk("wl_b1_last", acc_last, 1);
    step(); w_enq__ENA = 1'b0; w_last = 1'b0; #2;
    chk("wl_err_after", err_wlast, EXP_ERR);
    step(); step(); #2;
    chk("wl_err_sticky", err_wlast, EXP_ERR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
